qspi_psram_responder: RTL and testbench
=======================================

Name: qspi_psram_responder

Overview:
- Synthesizable QSPI memory responder: the target end of the quad SPI link that the SoC's qqspi initiator drives.
- Decodes the PSRAM quad read and quad write commands and serves them from an internal byte array.
- Used as an FPGA-side PSRAM stand-in and as the bus-functional memory in SoC-level benches.
- Samples the SPI pins with the fast system clock; sclk is treated as data, not as a clock.

Parameters:
- MEM_BYTES, 1024: internal byte array depth; power of two.
- DUMMY_CYCLES, 6: sclk cycles between the last address nibble and the first read data nibble.
- CMD_READ, 8'hEB: quad read opcode.
- CMD_WRITE, 8'h38: quad write opcode.
- SYNC_STAGES, 2: synchronizer depth on cen, sclk and sio_i.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- cen  in  1  chip enable from the initiator, active-low.
- sclk  in  1  SPI clock from the initiator, mode 0 (idle low).
- sio_i  in  4  sio3..sio0 input lanes.
- sio_o  out  4  output lanes.
- sio_oe  out  4  per-lane output enable; 4'b1111 or 4'b0000 only.
- busy  out  1  high while a transaction is in progress (synchronized cen low).
- cmd_err  out  1  one-clk pulse when an unknown opcode is received.
- bd_we  in  1  backdoor byte write strobe.
- bd_addr  in  $clog2(MEM_BYTES)  backdoor byte address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  backdoor read data; registered, 1 clk after bd_addr.

Behaviour:
- Reset: sio_o=0, sio_oe=0, busy=0, cmd_err=0, bd_rdata=0, FSM=IDLE, synchronizers cleared to cen=1, sclk=0. Memory contents are not cleared.
- Synchronization: cen, sclk and sio_i pass through SYNC_STAGES flops. An edge detector on synced sclk yields rise and fall pulses, so an edge is seen SYNC_STAGES+1 clk after the pin edge.
- Timing requirement: sclk high and low phases are each at least SYNC_STAGES+3 clk. Slower sclk is legal.
- Sampling: on a rise pulse. Driving: sio_o changes on a fall pulse only.
- Deselect: synced cen=1 in any state forces IDLE next clk, sio_oe=0, and clears the bit/nibble counters.
  - Takes priority over a simultaneous sclk edge.
  - An incomplete write byte is discarded.
- FSM states and transitions:
  - IDLE: cen low -> CMD, busy=1.
  - CMD: 8 rises, 1 bit per rise on sio0, MSB first. Opcode == CMD_READ or CMD_WRITE -> ADDR. Otherwise pulse cmd_err and go to IGNORE.
  - ADDR: 6 rises, 1 nibble per rise on sio3..0, MSB nibble first; 24-bit byte address. Bits above $clog2(MEM_BYTES) are ignored. Then read -> DUMMY, write -> WDATA.
  - DUMMY: count DUMMY_CYCLES rises.
    - The fall following the last dummy rise sets sio_oe=4'b1111 and drives the high nibble of mem[addr]. Then -> RDATA.
    - If DUMMY_CYCLES=0, that drive happens on the fall after the last address rise.
  - RDATA: each fall drives the next nibble: high nibble, then low nibble; addr increments after the low nibble. Continues until deselect.
  - WDATA: each rise captures a nibble, high nibble first. On the low-nibble rise, mem[addr] is written that clk and addr increments.
  - IGNORE: no sampling, no driving, until deselect.
- Address wrap: addr increments modulo MEM_BYTES, so reads and writes wrap from MEM_BYTES-1 to 0.
- Read-after-write inside one burst is not possible (separate commands). A write followed by a read in the next transaction returns the new data.
- Backdoor:
  - bd_we is honoured only while busy=0; ignored otherwise, with no queuing.
  - bd_rdata is always registered from mem[bd_addr].
- Memory: single write port, shared by SPI and backdoor under the busy exclusion; two read ports (SPI, backdoor). Maps to BRAM.
- Reset mid-transaction: FSM=IDLE and sio_oe=0 the next clk. A partial byte is lost; committed bytes remain.

Test Plan:
- Backdoor-write mem[0..3]=11,22,33,44; quad read EB at addr 0x000000, 8 data sclks -> sio nibbles 1,1,2,2,3,3,4,4; sio_oe=1111 from the fall after the 6th dummy rise until cen high.
- Quad write 38 at addr 0x000010, data A5,5A,C3 -> bd_rdata at 0x10..0x12 = A5,5A,C3; 0x13 unchanged.
- Write 38 at addr MEM_BYTES-1, data 77,88 -> mem[MEM_BYTES-1]=77, mem[0]=88; wrap verified by backdoor reads.
- Opcode 0x9F -> cmd_err one-clk pulse; sio_oe stays 0000; the following EB read to addr 0 returns correct data.
- Write 38 with 3 nibbles (F,E,D), cen raised mid-byte -> first byte FE written, second byte unchanged; busy=0 and sio_oe=0 within SYNC_STAGES+2 clk of cen rising.
- Assert rst during RDATA -> sio_oe=0 and busy=0 the next clk; bd_we during busy=1 -> no memory change.

Source files
------------

// File: rtl/qspi_psram_responder_if.sv
// rtl/qspi_psram_responder_if.sv - quad SPI pin bundle between initiator and responder
interface qspi_psram_responder_if;
    logic       cen;
    logic       sclk;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic [3:0] sio_oe;

    modport master (output cen, output sclk, output sio_i, input sio_o, input sio_oe);
    modport slave  (input cen, input sclk, input sio_i, output sio_o, output sio_oe);
endinterface

// File: rtl/qspi_psram_responder.sv
// rtl/qspi_psram_responder.sv - quad SPI PSRAM responder backed by an internal byte array
module qspi_psram_responder #(
    parameter int         MEM_BYTES    = 1024,
    parameter int         DUMMY_CYCLES = 6,
    parameter logic [7:0] CMD_READ     = 8'hEB,
    parameter logic [7:0] CMD_WRITE    = 8'h38,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    qspi_psram_responder_if.slave        spi,
    output logic                         busy,
    output logic                         cmd_err,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_BYTES)-1:0] bd_addr,
    input  logic [7:0]                   bd_wdata,
    output logic [7:0]                   bd_rdata
);
    localparam int         AW      = $clog2(MEM_BYTES);
    localparam logic [7:0] DUMMY_N = 8'(DUMMY_CYCLES);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

    state_t           state_q, state_d;
    logic [SYNC_STAGES-1:0] cen_q, sclk_q;
    logic [3:0]       sio_q [SYNC_STAGES];
    logic             sclk_prev;
    logic             cen_s, sclk_s, rise, fall;
    logic [3:0]       sio_s;
    logic [7:0]       cnt;
    logic [6:0]       op_q;
    logic [7:0]       opcode_nx;
    logic             op_ok, is_write, phase;
    logic [AW-1:0]    addr;
    logic [3:0]       wnib;
    logic [7:0]       spi_rdata;
    logic             spi_we;
    logic [3:0]       sio_o_q, sio_oe_q;
    logic [7:0]       mem [MEM_BYTES];

    assign cen_s     = cen_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign sio_s     = sio_q[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_prev;
    assign fall      = ~sclk_s & sclk_prev;
    assign opcode_nx = {op_q, sio_s[0]};
    assign op_ok     = (opcode_nx == CMD_READ) || (opcode_nx == CMD_WRITE);
    assign busy      = (state_q != IDLE);
    assign spi_we    = (state_q == WDATA) && rise && phase && !cen_s && !rst;
    assign spi.sio_o  = sio_o_q;
    assign spi.sio_oe = sio_oe_q;

    // Pin synchronizers; sclk is sampled as data and edge-detected after the last stage
    always_ff @(posedge clk) begin
        if (rst) begin
            cen_q     <= '1;
            sclk_q    <= '0;
            sclk_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sio_q[i] <= 4'h0;
        end else begin
            cen_q[0]  <= spi.cen;
            sclk_q[0] <= spi.sclk;
            sio_q[0]  <= spi.sio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cen_q[i]  <= cen_q[i-1];
                sclk_q[i] <= sclk_q[i-1];
                sio_q[i]  <= sio_q[i-1];
            end
            sclk_prev <= sclk_s;
        end
    end

    // Protocol state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode; deselect wins over any sclk edge
    always_comb begin
        state_d = state_q;
        if (cen_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = CMD;
                CMD:   if (rise && cnt == 8'd7) state_d = op_ok ? ADDR : IGNORE;
                ADDR:  if (rise && cnt == 8'd5) state_d = is_write ? WDATA : DUMMY;
                DUMMY: if (fall && cnt == DUMMY_N) state_d = RDATA;
                default: ;
            endcase
        end
    end

    // Shift-in of opcode/address, bit counting, nibble sequencing and pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 8'd0;
            op_q     <= 7'd0;
            is_write <= 1'b0;
            phase    <= 1'b0;
            addr     <= '0;
            wnib     <= 4'h0;
            sio_o_q  <= 4'h0;
            sio_oe_q <= 4'h0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (cen_s) begin
                cnt      <= 8'd0;
                phase    <= 1'b0;
                sio_oe_q <= 4'h0;
            end else begin
                case (state_q)
                    CMD: if (rise) begin
                        op_q <= opcode_nx[6:0];
                        if (cnt == 8'd7) begin
                            cnt      <= 8'd0;
                            is_write <= (opcode_nx == CMD_WRITE);
                            cmd_err  <= !op_ok;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ADDR: if (rise) begin
                        // Shifting straight into addr drops bits above the array size
                        addr <= AW'({addr, sio_s});
                        cnt  <= (cnt == 8'd5) ? 8'd0 : cnt + 8'd1;
                    end
                    DUMMY: begin
                        if (fall && cnt == DUMMY_N) begin
                            sio_oe_q <= 4'hF;
                            sio_o_q  <= spi_rdata[7:4];
                            phase    <= 1'b1;
                            cnt      <= 8'd0;
                        end else if (rise) begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    RDATA: if (fall) begin
                        if (phase) begin
                            sio_o_q <= spi_rdata[3:0];
                            addr    <= addr + AW'(1);
                        end else begin
                            sio_o_q <= spi_rdata[7:4];
                        end
                        phase <= ~phase;
                    end
                    WDATA: if (rise) begin
                        if (phase) addr <= addr + AW'(1);
                        else       wnib <= sio_s;
                        phase <= ~phase;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte array: one write port shared under busy exclusion, registered SPI read
    always_ff @(posedge clk) begin
        if (spi_we)
            mem[addr] <= {wnib, sio_s};
        else if (bd_we && !busy)
            mem[bd_addr] <= bd_wdata;
        spi_rdata <= mem[addr];
    end

    // Backdoor read port
    always_ff @(posedge clk) begin
        if (rst) bd_rdata <= 8'h00;
        else     bd_rdata <= mem[bd_addr];
    end
endmodule

// File: tb/tb_qspi_psram_responder.sv
// tb/tb_qspi_psram_responder.sv - directed self-checking bench for qspi_psram_responder
module tb_qspi_psram_responder;
    localparam int MEM  = 1024;
    localparam int AW   = 10;
    localparam int SYNC = 2;
    localparam int H    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qspi_psram_responder_if spi_if();
    logic          busy, cmd_err, bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_wdata, bd_rdata;

    qspi_psram_responder #(
        .MEM_BYTES(MEM), .DUMMY_CYCLES(6), .CMD_READ(8'hEB), .CMD_WRITE(8'h38), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .spi(spi_if), .busy(busy), .cmd_err(cmd_err),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    logic [7:0] ref_mem [MEM];
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [7:0] wq[$];
    logic [3:0] cmp_e;
    int chk_kind = 0;
    int n_checks = 0;
    int n_fail = 0;
    int cmd_err_cnt = 0;
    bit model_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int k);
        chk_kind = k;
        wclk(1);
        chk_kind = 0;
    endtask

    task automatic sclk_cycle(input logic [3:0] d, input int k);
        spi_if.sio_i = d;
        wclk(H - 1);
        strobe(k);
        spi_if.sclk = 1'b1;
        wclk(H);
        spi_if.sclk = 1'b0;
    endtask

    task automatic spi_begin();
        spi_if.cen = 1'b0;
        model_busy = 1'b1;
        wclk(H);
    endtask

    task automatic spi_end();
        wclk(H);
        spi_if.cen = 1'b1;
        wclk(SYNC + 2);
        check("deselect_busy", busy, 0);
        check("deselect_oe", spi_if.sio_oe, 4'h0);
        model_busy = 1'b0;
        wclk(4);
    endtask

    task automatic send_bits(input logic [7:0] op);
        for (int i = 0; i < 8; i++) sclk_cycle({3'b000, op[7-i]}, 1);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        logic [23:0] sh;
        spi_begin();
        send_bits(op);
        for (int i = 0; i < 6; i++) begin
            sh = a >> (20 - 4 * i);
            sclk_cycle(sh[3:0], 1);
        end
    endtask

    task automatic push_exp(input int a, input int nbytes);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = ref_mem[(a + i) % MEM];
            exp_q.push_back(b[7:4]);
            exp_q.push_back(b[3:0]);
        end
    endtask

    task automatic spi_read(input int a, input int nbytes);
        got_q.delete();
        push_exp(a, nbytes);
        send_hdr(8'hEB, 24'(a));
        for (int i = 0; i < 6; i++) sclk_cycle(4'h0, 1);
        for (int i = 0; i < 2 * nbytes; i++) sclk_cycle(4'h0, 2);
        spi_end();
    endtask

    task automatic spi_write(input int a, input int nnib);
        logic [7:0] b;
        send_hdr(8'h38, 24'(a));
        for (int i = 0; i < nnib; i++) begin
            b = wq[i / 2];
            sclk_cycle((i % 2 == 0) ? b[7:4] : b[3:0], 1);
        end
        for (int j = 0; j < nnib / 2; j++) ref_mem[(a + j) % MEM] = wq[j];
        spi_end();
    endtask

    task automatic bd_write(input int a, input logic [7:0] d);
        bd_addr  = AW'(a);
        bd_wdata = d;
        bd_we    = 1'b1;
        wclk(1);
        bd_we    = 1'b0;
        if (!model_busy) ref_mem[a] = d;
    endtask

    task automatic bd_model(input int a);
        bd_addr = AW'(a);
        wclk(2);
        strobe(3);
    endtask

    task automatic bd_lit(input int a, input logic [7:0] e, input string name);
        bd_addr = AW'(a);
        wclk(2);
        check(name, bd_rdata, e);
    endtask

    function automatic logic [31:0] got_word();
        logic [31:0] w = 32'h0;
        foreach (got_q[i]) w = {w[27:0], got_q[i]};
        return w;
    endfunction

    // Single compare process against the bench model
    always @(negedge clk) begin
        if (cmd_err === 1'b1) cmd_err_cnt++;
        if (chk_kind == 1) begin
            check("oe_not_driving", spi_if.sio_oe, 4'h0);
        end else if (chk_kind == 2) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_nibble: got %0h with no expected nibble queued", spi_if.sio_o);
            end else begin
                cmp_e = exp_q.pop_front();
                check("rd_oe", spi_if.sio_oe, 4'hF);
                check("rd_nibble", spi_if.sio_o, cmp_e);
                got_q.push_back(spi_if.sio_o);
            end
        end else if (chk_kind == 3) begin
            check("bd_model", bd_rdata, ref_mem[bd_addr]);
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        spi_if.cen   = 1'b1;
        spi_if.sclk  = 1'b0;
        spi_if.sio_i = 4'h0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = 8'h00;
        rst = 1'b1;
        wclk(3);
        check("rst_oe", spi_if.sio_oe, 4'h0);
        check("rst_sio_o", spi_if.sio_o, 4'h0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_bd_rdata", bd_rdata, 8'h00);
        rst = 1'b0;
        wclk(2);
        for (int a = 0; a < MEM; a++) bd_write(a, 8'(a * 7 + 3));

        // Backdoor preload then quad read of four bytes
        bd_write(0, 8'h11); bd_write(1, 8'h22); bd_write(2, 8'h33); bd_write(3, 8'h44);
        spi_read(0, 4);
        check("rd1_count", got_q.size(), 8);
        check("rd1_word", got_word(), 32'h11223344);
        check("no_cmd_err", cmd_err_cnt, 0);

        // Quad write of three bytes at 0x10
        wq = '{8'hA5, 8'h5A, 8'hC3};
        spi_write(24'h10, 6);
        bd_lit(16'h10, 8'hA5, "wr_10");
        bd_lit(16'h11, 8'h5A, "wr_11");
        bd_lit(16'h12, 8'hC3, "wr_12");
        bd_lit(16'h13, 8'h88, "wr_13_unchanged");
        for (int a = 16; a < 20; a++) bd_model(a);

        // Write wrapping from the top of the array to 0
        wq = '{8'h77, 8'h88};
        spi_write(MEM - 1, 4);
        bd_lit(MEM - 1, 8'h77, "wrap_top");
        bd_lit(0, 8'h88, "wrap_zero");
        bd_model(1);

        // Unknown opcode: error pulse, no drive, then a clean read
        spi_begin();
        send_bits(8'h9F);
        for (int i = 0; i < 6; i++) sclk_cycle(4'hA, 1);
        spi_end();
        check("cmd_err_pulse", cmd_err_cnt, 1);
        spi_read(0, 2);
        check("rd_after_err", got_word(), 32'h8822);

        // Deselect mid-byte: only the completed byte lands
        wq = '{8'hFE, 8'hDC};
        spi_write(24'h20, 3);
        bd_lit(16'h20, 8'hFE, "partial_first");
        bd_lit(16'h21, 8'hEA, "partial_second");
        bd_model(16'h21);

        // Reset during read data, with a backdoor write attempted while busy
        got_q.delete();
        push_exp(16'h10, 1);
        send_hdr(8'hEB, 24'h10);
        check("busy_mid", busy, 1);
        bd_write(5, 8'h00);
        for (int i = 0; i < 6; i++) sclk_cycle(4'h0, 1);
        for (int i = 0; i < 2; i++) sclk_cycle(4'h0, 2);
        wclk(2);
        rst = 1'b1;
        wclk(1);
        check("rst_mid_oe", spi_if.sio_oe, 4'h0);
        check("rst_mid_busy", busy, 0);
        spi_if.cen = 1'b1;
        wclk(3);
        rst = 1'b0;
        model_busy = 1'b0;
        exp_q.delete();
        wclk(4);
        bd_lit(5, 8'h26, "bd_we_while_busy");
        bd_model(5);

        // Read wrapping across the end of the array
        spi_read(MEM - 2, 3);
        check("rd_wrap", got_word(), 32'hF57788);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
